rv32i_decode: RTL and testbench

- Registered RV32I base-integer instruction decoder.
- Takes the PC and the 32-bit instruction word from the fetch stage and splits it into register indices, a sign-extended immediate, an instruction format code, an ALU operation and control flags.
- Also computes the PC-relative target for branches and JAL, and flags illegal encodings.
- Sits between fetch and execute; outputs are valid one clock after the inputs are presented.

---
 rtl/rv32i_decode.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_rv32i_decode.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode.sv
// rv32i_decode: registered RV32I base-integer decoder between fetch and execute.
// One instruction is accepted every cycle; the decoded fields appear one clock
// after pc_i/instr_i are sampled. Illegal encodings decode to a quiet bundle
// (format NONE, no enables) with illegal_o raised.
module rv32i_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_imm_o,
  output logic            rd_we_o,
  output logic            rs1_en_o,
  output logic            rs2_en_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            is_branch_o,
  output logic            is_jal_o,
  output logic            is_jalr_o,
  output logic            is_auipc_o,
  output logic            is_system_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Everything the execute stage sees, captured as one register.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    alu_e            alu_op;
    logic            alu_src_imm;
    logic            rd_we;
    logic            rs1_en;
    logic            rs2_en;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_auipc;
    logic            is_system;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] target;
    logic            illegal;
  } dec_t;

  // OP and OP-IMM share the funct3 -> ALU mapping; alt picks SUB/SRA.
  function automatic alu_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_e op;
    op = ALU_ADD;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  logic legal;
  logic shift_imm;
  logic writes_rd;
  logic reads_rs1;
  logic reads_rs2;
  dec_t d;
  dec_t q;

  // Decode the current instruction word into the next output bundle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    d         = '0;
    legal     = 1'b1;
    shift_imm = 1'b0;
    writes_rd = 1'b0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    d.valid   = 1'b1;
    d.pc      = pc_i;
    d.fmt     = FMT_NONE;
    d.alu_op  = ALU_ADD;

    case (opcode)
      OPC_OP: begin
        d.fmt     = FMT_R;
        legal     = (funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
        d.alu_op  = alu_from_funct3(funct3, funct7[5]);
        writes_rd = 1'b1;
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        d.fmt         = FMT_I;
        d.alu_src_imm = 1'b1;
        writes_rd     = 1'b1;
        reads_rs1     = 1'b1;
        // Only the shifts carry a funct7; ADDI's upper bits are immediate.
        if (funct3 == 3'd1) begin
          shift_imm = 1'b1;
          legal     = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          shift_imm = 1'b1;
          legal     = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
        d.alu_op = alu_from_funct3(funct3, shift_imm & funct7[5]);
      end
      OPC_LOAD: begin
        d.fmt          = FMT_I;
        d.alu_src_imm  = 1'b1;
        d.is_load      = 1'b1;
        d.mem_size     = funct3[1:0];
        d.mem_unsigned = funct3[2];
        legal          = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        writes_rd      = 1'b1;
        reads_rs1      = 1'b1;
      end
      OPC_STORE: begin
        d.fmt         = FMT_S;
        d.alu_src_imm = 1'b1;
        d.is_store    = 1'b1;
        d.mem_size    = funct3[1:0];
        legal         = (funct3 <= 3'd2);
        reads_rs1     = 1'b1;
        reads_rs2     = 1'b1;
      end
      OPC_BRANCH: begin
        d.fmt       = FMT_B;
        d.alu_op    = ALU_SUB;
        d.is_branch = 1'b1;
        legal       = (funct3 != 3'd2) && (funct3 != 3'd3);
        reads_rs1   = 1'b1;
        reads_rs2   = 1'b1;
      end
      OPC_JAL: begin
        d.fmt     = FMT_J;
        d.is_jal  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        d.fmt         = FMT_I;
        d.alu_src_imm = 1'b1;
        d.is_jalr     = 1'b1;
        legal         = (funct3 == 3'd0);
        writes_rd     = 1'b1;
        reads_rs1     = 1'b1;
      end
      OPC_LUI: begin
        d.fmt         = FMT_U;
        d.alu_op      = ALU_PASSB;
        d.alu_src_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        d.fmt         = FMT_U;
        d.alu_src_imm = 1'b1;
        d.is_auipc    = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_FENCE: begin
        // Single-hart in-order pipeline: FENCE has nothing to order.
        d.fmt = FMT_NONE;
      end
      OPC_SYSTEM: begin
        // ECALL/EBREAK are I-type with imm 0/1; they touch no registers.
        d.fmt       = FMT_I;
        d.is_system = 1'b1;
        legal       = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
      end
      default: legal = 1'b0;
    endcase

    // Route fields by format; unused indices read as zero.
    case (d.fmt)
      FMT_R: begin
        d.rd  = rd_f;
        d.rs1 = rs1_f;
        d.rs2 = rs2_f;
      end
      FMT_I: begin
        d.rd  = rd_f;
        d.rs1 = rs1_f;
        d.imm = shift_imm ? {{(XLEN-5){1'b0}}, rs2_f} : imm_i;
      end
      FMT_S: begin
        d.rs1 = rs1_f;
        d.rs2 = rs2_f;
        d.imm = imm_s;
      end
      FMT_B: begin
        d.rs1 = rs1_f;
        d.rs2 = rs2_f;
        d.imm = imm_b;
      end
      FMT_U: begin
        d.rd  = rd_f;
        d.imm = imm_u;
      end
      FMT_J: begin
        d.rd  = rd_f;
        d.imm = imm_j;
      end
      default: ;
    endcase

    d.rd_we  = writes_rd && (rd_f != 5'd0);
    d.rs1_en = reads_rs1;
    d.rs2_en = reads_rs2;
    if (d.fmt == FMT_B || d.fmt == FMT_J) begin
      d.target = pc_i + d.imm;
    end

    if (!legal) begin
      d         = '0;
      d.valid   = 1'b1;
      d.pc      = pc_i;
      d.fmt     = FMT_NONE;
      d.illegal = 1'b1;
    end
  end

  // Output register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!rst_n_i) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

`ifndef NDEBUG
  // Report an illegal instruction with its PC as soon as it is decoded.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (legal)
        else $error("rv32i_decode: illegal instruction %08h at pc %08h", instr_i, pc_i);
    end
  end
`endif

  assign valid_o        = q.valid;
  assign pc_o           = q.pc;
  assign rd_o           = q.rd;
  assign rs1_o          = q.rs1;
  assign rs2_o          = q.rs2;
  assign imm_o          = q.imm;
  assign fmt_o          = q.fmt;
  assign alu_op_o       = q.alu_op;
  assign alu_src_imm_o  = q.alu_src_imm;
  assign rd_we_o        = q.rd_we;
  assign rs1_en_o       = q.rs1_en;
  assign rs2_en_o       = q.rs2_en;
  assign is_load_o      = q.is_load;
  assign is_store_o     = q.is_store;
  assign is_branch_o    = q.is_branch;
  assign is_jal_o       = q.is_jal;
  assign is_jalr_o      = q.is_jalr;
  assign is_auipc_o     = q.is_auipc;
  assign is_system_o    = q.is_system;
  assign mem_size_o     = q.mem_size;
  assign mem_unsigned_o = q.mem_unsigned;
  assign target_o       = q.target;
  assign illegal_o      = q.illegal;

endmodule

// File: tb/tb_rv32i_decode.sv
// tb_rv32i_decode: directed and random checks of rv32i_decode against a
// reference decoder built from the RV32I field rules with plain arithmetic.
module tb_rv32i_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;

  logic        valid;
  logic [31:0] pc_q;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        rd_we;
  logic        rs1_en;
  logic        rs2_en;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        is_auipc;
  logic        is_system;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] target;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_decode #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pc_i           (pc),
    .instr_i        (instr),
    .valid_o        (valid),
    .pc_o           (pc_q),
    .rd_o           (rd),
    .rs1_o          (rs1),
    .rs2_o          (rs2),
    .imm_o          (imm),
    .fmt_o          (fmt),
    .alu_op_o       (alu_op),
    .alu_src_imm_o  (alu_src_imm),
    .rd_we_o        (rd_we),
    .rs1_en_o       (rs1_en),
    .rs2_en_o       (rs2_en),
    .is_load_o      (is_load),
    .is_store_o     (is_store),
    .is_branch_o    (is_branch),
    .is_jal_o       (is_jal),
    .is_jalr_o      (is_jalr),
    .is_auipc_o     (is_auipc),
    .is_system_o    (is_system),
    .mem_size_o     (mem_size),
    .mem_unsigned_o (mem_unsigned),
    .target_o       (target),
    .illegal_o      (illegal)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [3:0]  alu_op;
    logic        alu_src_imm, rd_we, rs1_en, rs2_en;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_system;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  // ALU codes indexed by funct3 for the non-alternate encodings.
  int alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic exp_t zero_bundle();
    exp_t e;
    e.valid = 0; e.pc = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
    e.fmt = 0; e.alu_op = 0; e.alu_src_imm = 0; e.rd_we = 0;
    e.rs1_en = 0; e.rs2_en = 0; e.is_load = 0; e.is_store = 0;
    e.is_branch = 0; e.is_jal = 0; e.is_jalr = 0; e.is_auipc = 0;
    e.is_system = 0; e.mem_size = 0; e.mem_unsigned = 0; e.target = 0;
    e.illegal = 0;
    return e;
  endfunction

  // Reference decode from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] p, input logic [31:0] w);
    exp_t e;
    int op, f3, f7, form, sx, top;
    int ii, si, bi, ui, ji;
    bit ok, wr;
    e    = zero_bundle();
    op   = int'(w[6:0]);
    f3   = int'(w[14:12]);
    f7   = int'(w[31:25]);
    sx   = int'(w);
    top  = sx >>> 31;
    ii   = sx >>> 20;
    si   = ((sx >>> 25) * 32) + int'(w[11:7]);
    bi   = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    ui   = sx - int'(w[11:0]);
    ji   = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    ok   = 1;
    wr   = 0;
    form = 7;
    e.valid = 1;
    e.pc    = p;
    case (op)
      'h33: begin
        form = 0; wr = 1; e.rs1_en = 1; e.rs2_en = 1;
        ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
        e.alu_op = 4'(alu_base[f3] + ((f7 == 'h20) ? 1 : 0));
      end
      'h13: begin
        form = 1; wr = 1; e.rs1_en = 1; e.alu_src_imm = 1;
        e.imm = ii;
        e.alu_op = 4'(alu_base[f3]);
        if (f3 == 1) begin
          ok = (f7 == 0); e.imm = 32'(w[24:20]);
        end else if (f3 == 5) begin
          ok = (f7 == 0 || f7 == 'h20); e.imm = 32'(w[24:20]);
          if (f7 == 'h20) e.alu_op = 4'd7;
        end
      end
      'h03: begin
        form = 1; wr = 1; e.rs1_en = 1; e.alu_src_imm = 1; e.is_load = 1;
        e.imm = ii; ok = (f3 != 3 && f3 != 6 && f3 != 7);
        e.mem_size = 2'(f3 % 4); e.mem_unsigned = (f3 >= 4);
      end
      'h23: begin
        form = 2; e.rs1_en = 1; e.rs2_en = 1; e.alu_src_imm = 1; e.is_store = 1;
        e.imm = si; ok = (f3 < 3); e.mem_size = 2'(f3 % 4);
      end
      'h63: begin
        form = 3; e.rs1_en = 1; e.rs2_en = 1; e.is_branch = 1; e.alu_op = 1;
        e.imm = bi; ok = (f3 != 2 && f3 != 3);
      end
      'h6F: begin form = 5; wr = 1; e.is_jal = 1; e.imm = ji; end
      'h67: begin
        form = 1; wr = 1; e.rs1_en = 1; e.alu_src_imm = 1; e.is_jalr = 1;
        e.imm = ii; ok = (f3 == 0);
      end
      'h37: begin form = 4; wr = 1; e.alu_src_imm = 1; e.alu_op = 10; e.imm = ui; end
      'h17: begin form = 4; wr = 1; e.alu_src_imm = 1; e.is_auipc = 1; e.imm = ui; end
      'h0F: form = 7;
      'h73: begin
        form = 1; e.is_system = 1; e.imm = ii;
        ok = (w == 32'h0000_0073 || w == 32'h0010_0073);
      end
      default: ok = 0;
    endcase
    e.fmt = 3'(form);
    if (form == 0 || form == 1 || form == 4 || form == 5) e.rd = w[11:7];
    if (form <= 3) e.rs1 = w[19:15];
    if (form == 0 || form == 2 || form == 3) e.rs2 = w[24:20];
    e.rd_we = wr && (w[11:7] != 0);
    if (form == 3 || form == 5) e.target = p + e.imm;
    if (!ok) begin
      e = zero_bundle();
      e.valid = 1; e.pc = p; e.fmt = 7; e.illegal = 1;
    end
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".valid"},     32'(valid),        32'(e.valid));
    check({tag, ".pc"},        pc_q,              e.pc);
    check({tag, ".rd"},        32'(rd),           32'(e.rd));
    check({tag, ".rs1"},       32'(rs1),          32'(e.rs1));
    check({tag, ".rs2"},       32'(rs2),          32'(e.rs2));
    check({tag, ".imm"},       imm,               e.imm);
    check({tag, ".fmt"},       32'(fmt),          32'(e.fmt));
    check({tag, ".alu_op"},    32'(alu_op),       32'(e.alu_op));
    check({tag, ".src_imm"},   32'(alu_src_imm),  32'(e.alu_src_imm));
    check({tag, ".rd_we"},     32'(rd_we),        32'(e.rd_we));
    check({tag, ".rs1_en"},    32'(rs1_en),       32'(e.rs1_en));
    check({tag, ".rs2_en"},    32'(rs2_en),       32'(e.rs2_en));
    check({tag, ".load"},      32'(is_load),      32'(e.is_load));
    check({tag, ".store"},     32'(is_store),     32'(e.is_store));
    check({tag, ".branch"},    32'(is_branch),    32'(e.is_branch));
    check({tag, ".jal"},       32'(is_jal),       32'(e.is_jal));
    check({tag, ".jalr"},      32'(is_jalr),      32'(e.is_jalr));
    check({tag, ".auipc"},     32'(is_auipc),     32'(e.is_auipc));
    check({tag, ".system"},    32'(is_system),    32'(e.is_system));
    check({tag, ".mem_size"},  32'(mem_size),     32'(e.mem_size));
    check({tag, ".mem_uns"},   32'(mem_unsigned), 32'(e.mem_unsigned));
    check({tag, ".target"},    target,            e.target);
    check({tag, ".illegal"},   32'(illegal),      32'(e.illegal));
  endtask

  // Present one instruction on the falling edge, check it after the next rise.
  task automatic step(input string tag, input logic r, input logic [31:0] p, input logic [31:0] w);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    pc    = p;
    instr = w;
    e     = r ? ref_decode(p, w) : zero_bundle();
    @(posedge clk);
    #1;
    compare_all(tag, e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    logic [31:0] w;
    int          pick;
    w    = $urandom;
    pick = int'($urandom_range(0, 14));
    if (pick < 11) w[6:0] = ops[pick];
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    if (w[6:0] == 7'h73 && $urandom_range(0, 2) != 0)
      w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
    return w;
  endfunction

  initial begin
    $assertoff;
    rst_n = 1'b0;
    pc    = '0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid",   32'(valid),   32'd0);
    check("reset.fmt",     32'(fmt),     32'd0);
    check("reset.illegal", 32'(illegal), 32'd0);
    check("reset.pc",      pc_q,         32'd0);

    // First decode after reset: outputs must not change before the edge.
    @(negedge clk);
    rst_n = 1'b1;
    pc    = 32'h0000_1000;
    instr = 32'h0050_0093;
    #1;
    check("addi.latency_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check("addi.fmt",     32'(fmt),         32'd1);
    check("addi.rd",      32'(rd),          32'd1);
    check("addi.rs1",     32'(rs1),         32'd0);
    check("addi.imm",     imm,              32'd5);
    check("addi.alu",     32'(alu_op),      32'd0);
    check("addi.src_imm", 32'(alu_src_imm), 32'd1);
    check("addi.rd_we",   32'(rd_we),       32'd1);
    check("addi.valid",   32'(valid),       32'd1);
    compare_all("addi", ref_decode(32'h0000_1000, 32'h0050_0093));

    step("sub", 1'b1, 32'h0000_1004, 32'h4020_81B3);
    check("sub.fmt", 32'(fmt), 32'd0);
    check("sub.rd",  32'(rd),  32'd3);
    check("sub.rs1", 32'(rs1), 32'd1);
    check("sub.rs2", 32'(rs2), 32'd2);
    check("sub.alu", 32'(alu_op), 32'd1);

    step("sub_bad_f7", 1'b1, 32'h0000_1008, 32'h0220_81B3);
    check("sub_bad_f7.illegal", 32'(illegal), 32'd1);
    check("sub_bad_f7.fmt",     32'(fmt),     32'd7);

    step("sw", 1'b1, 32'h0000_100C, 32'h0020_A423);
    check("sw.fmt",   32'(fmt),      32'd2);
    check("sw.imm",   imm,           32'd8);
    check("sw.store", 32'(is_store), 32'd1);
    check("sw.size",  32'(mem_size), 32'd2);
    check("sw.rd_we", 32'(rd_we),    32'd0);

    step("beq", 1'b1, 32'h8000_0010, 32'hFE00_0EE3);
    check("beq.imm",    imm,              32'hFFFF_FFFC);
    check("beq.target", target,           32'h8000_000C);
    check("beq.branch", 32'(is_branch),   32'd1);

    step("lui", 1'b1, 32'h0000_1010, 32'h1234_52B7);
    check("lui.fmt", 32'(fmt),    32'd4);
    check("lui.imm", imm,         32'h1234_5000);
    check("lui.alu", 32'(alu_op), 32'd10);
    check("lui.rd",  32'(rd),     32'd5);

    // JAL near the top of the address space wraps the target.
    step("jal_wrap", 1'b1, 32'hFFFF_FFF0, 32'h0200_00EF);
    step("jal_x0",   1'b1, 32'h0000_2000, 32'h0080_006F);
    step("ebreak",   1'b1, 32'h0000_2004, 32'h0010_0073);
    step("fence",    1'b1, 32'h0000_2008, 32'h0FF0_000F);

    step("zero_word", 1'b1, 32'h0000_1014, 32'h0000_0000);
    check("zero_word.illegal", 32'(illegal), 32'd1);

    // Mid-stream reset clears every output at the next edge.
    step("mid_reset", 1'b0, 32'h0000_1018, 32'h0050_0093);
    check("mid_reset.valid",   32'(valid),   32'd0);
    check("mid_reset.illegal", 32'(illegal), 32'd0);
    check("mid_reset.fmt",     32'(fmt),     32'd0);

    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] p;
      r = ($urandom_range(0, 39) != 0);
      p = $urandom & 32'hFFFF_FFFC;
      step($sformatf("rand%0d", i), r, p, rand_instr());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
